// File: rtl/pattern_generator_stream_pkg.sv
// Shared definitions for the stream test-pattern generator.
//   mode_e       : 3-bit pattern selector driven on the mode port
//   lfsr_taps()  : Galois feedback mask per LFSR width (MSB always set)
//   mode_active(): true for modes that actually emit lines
package pattern_gen_pkg;

    localparam int CB_LOG2_W = 2;

    typedef enum logic [2:0] {
        MODE_DISABLED = 3'd0,
        MODE_COUNT    = 3'd1,
        MODE_CONST    = 3'd2,
        MODE_CHECK    = 3'd3,
        MODE_RAMP     = 3'd4,
        MODE_HBAR     = 3'd5,
        MODE_NOISE    = 3'd6,
        MODE_RSVD     = 3'd7
    } mode_e;

    // Maximal-length right-shift Galois masks. The fallback keeps only the
    // MSB tap, which still makes the step invertible so a non-zero state
    // can never collapse to zero.
    function automatic logic [31:0] lfsr_taps(input int unsigned dw);
        case (dw)
            32'd3:   lfsr_taps = 32'h0000_0006;
            32'd4:   lfsr_taps = 32'h0000_000C;
            32'd5:   lfsr_taps = 32'h0000_0014;
            32'd6:   lfsr_taps = 32'h0000_0030;
            32'd7:   lfsr_taps = 32'h0000_0060;
            32'd8:   lfsr_taps = 32'h0000_00B8;
            32'd9:   lfsr_taps = 32'h0000_0110;
            32'd10:  lfsr_taps = 32'h0000_0240;
            32'd11:  lfsr_taps = 32'h0000_0500;
            32'd12:  lfsr_taps = 32'h0000_0E08;
            32'd13:  lfsr_taps = 32'h0000_1C80;
            32'd14:  lfsr_taps = 32'h0000_3802;
            32'd15:  lfsr_taps = 32'h0000_6000;
            32'd16:  lfsr_taps = 32'h0000_B400;
            32'd24:  lfsr_taps = 32'h00E1_0000;
            32'd32:  lfsr_taps = 32'h8020_0003;
            default: lfsr_taps = 32'd1 << (dw - 32'd1);
        endcase
    endfunction

    function automatic logic mode_active(input mode_e m);
        mode_active = (m != MODE_DISABLED) && (m != MODE_RSVD);
    endfunction

endpackage

// File: rtl/pattern_generator_stream_lfsr.sv
// Galois LFSR used for the NOISE pattern.
//   clk, rst : clock, synchronous active-high reset
//   load     : load seed (a zero seed is replaced by 1)
//   seed     : seed value
//   en       : advance one step (ignored while load is high)
//   state    : value the register takes at the next edge, so the caller
//              can register it alongside the pixel it belongs to
module pattern_lfsr
    import pattern_gen_pkg::*;
#(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] seed,
    input  logic          en,
    output logic [DW-1:0] state
);

    localparam logic [DW-1:0] TAPS = DW'(lfsr_taps(DW));

    logic [DW-1:0] state_q;
    logic [DW-1:0] state_d;

    function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s);
        lfsr_step = (s >> 1) ^ (s[0] ? TAPS : {DW{1'b0}});
    endfunction

    // Next-state selection: load wins over advance.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (seed == {DW{1'b0}}) ? DW'(1) : seed;
        end else if (en) begin
            state_d = lfsr_step(state_q);
        end else begin
            state_d = state_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DW'(1);
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_d;

endmodule

// File: rtl/pattern_generator_stream.sv
// Sync-driven test-pattern generator with a valid/ready pixel stream.
// Every accepted sync emits one line of H_ACT pixels; f_sync together with
// sync starts a frame and latches the configuration shadow.
//   clk, rst           : clock, synchronous active-high reset
//   f_sync, sync       : frame start (qualified by sync), line start
//   mode .. cb_inv     : pattern configuration (sampled at frame start)
//   pix_data/valid/ready, pix_sol/eol/sof : output stream and line/frame flags
//   line_busy          : a line is being emitted
//   sync_err           : sticky, sync arrived while a line was still running
module pattern_generator_stream
    import pattern_gen_pkg::*;
#(
    parameter int DW    = 12,
    parameter int H_ACT = 1350,
    parameter int V_ACT = 24,
    parameter int DXW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 f_sync,
    input  logic                 sync,
    input  logic [2:0]           mode,
    input  logic [DW-1:0]        const_val,
    input  logic [DXW-1:0]       dx,
    input  logic [DXW-1:0]       dy,
    input  logic [CB_LOG2_W-1:0] cb_log2,
    input  logic                 cb_inv,
    output logic [DW-1:0]        pix_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 pix_sol,
    output logic                 pix_eol,
    output logic                 pix_sof,
    output logic                 line_busy,
    output logic                 sync_err
);

    localparam int XW = $clog2(H_ACT + 1);
    localparam int YW = $clog2(V_ACT + 1);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);

    // configuration shadow
    mode_e                mode_q,    mode_d;
    logic [DW-1:0]        const_q,   const_d;
    logic [DXW-1:0]       dx_q,      dx_d;
    logic [DXW-1:0]       dy_q,      dy_d;
    logic [CB_LOG2_W-1:0] cb_log2_q, cb_log2_d;
    logic                 cb_inv_q,  cb_inv_d;

    // position / generator state of the pixel currently presented
    logic [XW-1:0] x_q,   x_d;
    logic [YW-1:0] y_q,   y_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] row_q, row_d;
    logic [DW-1:0] acc_q, acc_d;

    // output register
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic          sol_q,   sol_d;
    logic          eol_q,   eol_d;
    logic          sof_q,   sof_d;
    logic          err_q,   err_d;

    logic          xfer;
    logic          can_start;
    logic          frame_start;
    logic          start;
    mode_e         mode_eff;
    logic          lfsr_load;
    logic          lfsr_en;
    logic [DW-1:0] lfsr_nxt;

    function automatic logic [DW-1:0] pix_value(
        input mode_e                m,
        input logic [XW-1:0]        x,
        input logic [YW-1:0]        y,
        input logic [DW-1:0]        cnt,
        input logic [DW-1:0]        acc,
        input logic [DW-1:0]        noise,
        input logic [DW-1:0]        cval,
        input logic [CB_LOG2_W-1:0] cb,
        input logic                 inv
    );
        logic [3:0] xe;
        logic [3:0] ye;
        logic       cb_bit;
        // tile size tops out at 8, so bits 0..3 of x/y are all that matter
        xe     = 4'(x);
        ye     = 4'(y);
        cb_bit = xe[cb] ^ ye[cb] ^ inv;
        case (m)
            MODE_COUNT: pix_value = cnt;
            MODE_CONST: pix_value = cval;
            MODE_CHECK: pix_value = {DW{cb_bit}};
            MODE_RAMP:  pix_value = acc;
            MODE_HBAR:  pix_value = {DW{y[0]}};
            MODE_NOISE: pix_value = noise;
            default:    pix_value = {DW{1'b0}};
        endcase
    endfunction

    pattern_lfsr #(.DW(DW)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (const_val),
        .en    (lfsr_en),
        .state (lfsr_nxt)
    );

    // Line acceptance, shadow latch, counters and next output pixel.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        acc_d     = acc_q;
        valid_d   = valid_q;
        data_d    = data_q;
        sol_d     = sol_q;
        eol_d     = eol_q;
        sof_d     = sof_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;

        xfer        = valid_q & pix_ready;
        // a new line may start when idle, or right as the eol pixel leaves
        can_start   = ~valid_q | (xfer & eol_q);
        frame_start = sync & f_sync & can_start;
        // a frame start is judged against the configuration it brings in
        mode_eff    = frame_start ? mode_e'(mode) : mode_q;
        start       = sync & can_start & mode_active(mode_eff);

        mode_d    = mode_eff;
        const_d   = frame_start ? const_val : const_q;
        dx_d      = frame_start ? dx        : dx_q;
        dy_d      = frame_start ? dy        : dy_q;
        cb_log2_d = frame_start ? cb_log2   : cb_log2_q;
        cb_inv_d  = frame_start ? cb_inv    : cb_inv_q;

        if (sync && !can_start) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        if (start) begin
            valid_d = 1'b1;
            sol_d   = 1'b1;
            sof_d   = f_sync;
            x_d     = {XW{1'b0}};
            if (f_sync) begin
                y_d       = {YW{1'b0}};
                cnt_d     = {DW{1'b0}};
                row_d     = const_val;
                acc_d     = const_val;
                lfsr_load = 1'b1;
            end else begin
                y_d     = (y_q == Y_LAST) ? {YW{1'b0}} : y_q + YW'(1);
                // a coincident eol transfer still counts toward the frame
                cnt_d   = cnt_q + DW'(xfer);
                row_d   = row_q + DW'(dy_q);
                acc_d   = row_q + DW'(dy_q);
                lfsr_en = xfer;
            end
        end else if (xfer) begin
            cnt_d   = cnt_q + DW'(1);
            lfsr_en = 1'b1;
            sol_d   = 1'b0;
            sof_d   = 1'b0;
            if (eol_q) begin
                valid_d = 1'b0;
            end else begin
                x_d   = x_q + XW'(1);
                acc_d = acc_q + DW'(dx_q);
            end
        end else begin
            valid_d = valid_q;
        end

        if (start || xfer) begin
            eol_d = valid_d & (x_d == X_LAST);
        end else begin
            eol_d = eol_q;
        end

        if (start || (xfer && !eol_q)) begin
            data_d = pix_value(mode_d, x_d, y_d, cnt_d, acc_d, lfsr_nxt,
                               const_d, cb_log2_d, cb_inv_d);
        end else if (xfer) begin
            data_d = {DW{1'b0}};
        end else begin
            data_d = data_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_DISABLED;
            const_q   <= {DW{1'b0}};
            dx_q      <= {DXW{1'b0}};
            dy_q      <= {DXW{1'b0}};
            cb_log2_q <= {CB_LOG2_W{1'b0}};
            cb_inv_q  <= 1'b0;
            x_q       <= {XW{1'b0}};
            y_q       <= {YW{1'b0}};
            cnt_q     <= {DW{1'b0}};
            row_q     <= {DW{1'b0}};
            acc_q     <= {DW{1'b0}};
            valid_q   <= 1'b0;
            data_q    <= {DW{1'b0}};
            sol_q     <= 1'b0;
            eol_q     <= 1'b0;
            sof_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            const_q   <= const_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            cb_log2_q <= cb_log2_d;
            cb_inv_q  <= cb_inv_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            acc_q     <= acc_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            sol_q     <= sol_d;
            eol_q     <= eol_d;
            sof_q     <= sof_d;
            err_q     <= err_d;
        end
    end

    assign pix_data  = data_q;
    assign pix_valid = valid_q;
    assign pix_sol   = sol_q;
    assign pix_eol   = eol_q;
    assign pix_sof   = sof_q;
    assign line_busy = valid_q;
    assign sync_err  = err_q;

endmodule

// File: tb/tb_pattern_generator_stream.sv
// Scoreboard bench for pattern_generator_stream (DW=8, H_ACT=8, V_ACT=4).
// Expected pixels are pushed when a sync the model accepts is driven, and
// checked against the presented pixel every cycle valid is high (so stalled
// pixels must hold); the entry is popped when the pixel transfers.
module tb_pattern_generator_stream;
    import pattern_gen_pkg::*;

    localparam int DW    = 8;
    localparam int H_ACT = 8;
    localparam int V_ACT = 4;
    localparam int DXW   = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           f_sync;
    logic           sync;
    logic [2:0]     mode;
    logic [DW-1:0]  const_val;
    logic [DXW-1:0] dx;
    logic [DXW-1:0] dy;
    logic [1:0]     cb_log2;
    logic           cb_inv;
    logic [DW-1:0]  pix_data;
    logic           pix_valid;
    logic           pix_ready;
    logic           pix_sol;
    logic           pix_eol;
    logic           pix_sof;
    logic           line_busy;
    logic           sync_err;

    int total_cnt = 0;
    int bad_cnt   = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sol;
        logic          eol;
        logic          sof;
    } exp_t;
    exp_t sb_q[$];

    // reference model state
    logic [2:0]    m_mode = 3'd0;
    logic [DW-1:0] m_const;
    logic [DW-1:0] m_lfsr;
    int            m_dx, m_dy, m_cb, m_inv, m_y, m_idx;

    bit         bp_en  = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    logic [1:0] bp_ph  = 2'd0;

    always #5 clk = ~clk;

    pattern_generator_stream #(.DW(DW), .H_ACT(H_ACT), .V_ACT(V_ACT), .DXW(DXW)) dut (
        .clk(clk), .rst(rst), .f_sync(f_sync), .sync(sync), .mode(mode),
        .const_val(const_val), .dx(dx), .dy(dy), .cb_log2(cb_log2), .cb_inv(cb_inv),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof),
        .line_busy(line_busy), .sync_err(sync_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_pix(input int x);
        logic [3:0] xb;
        logic [3:0] yb;
        logic       b;
        xb = 4'(x);
        yb = 4'(m_y);
        b  = xb[m_cb] ^ yb[m_cb] ^ m_inv[0];
        case (m_mode)
            3'd1:    model_pix = m_idx[DW-1:0];
            3'd2:    model_pix = m_const;
            3'd3:    model_pix = {DW{b}};
            3'd4:    model_pix = DW'(int'(m_const) + x * m_dx + m_y * m_dy);
            3'd5:    model_pix = {DW{yb[0]}};
            3'd6:    model_pix = m_lfsr;
            default: model_pix = {DW{1'b0}};
        endcase
    endfunction

    task automatic push_line(input bit first);
        exp_t e;
        logic lsb;
        for (int x = 0; x < H_ACT; x++) begin
            e.d   = model_pix(x);
            e.sol = (x == 0);
            e.eol = (x == H_ACT - 1);
            e.sof = first && (x == 0);
            sb_q.push_back(e);
            m_idx++;
            lsb    = m_lfsr[0];
            m_lfsr = m_lfsr >> 1;
            if (lsb) m_lfsr = m_lfsr ^ 8'hB8;
        end
    endtask

    task automatic model_start(input bit f);
        if (f) begin
            m_mode  = mode;
            m_const = const_val;
            m_dx    = int'(dx);
            m_dy    = int'(dy);
            m_cb    = int'(cb_log2);
            m_inv   = int'(cb_inv);
            m_y     = 0;
            m_idx   = 0;
            m_lfsr  = (const_val == 8'd0) ? 8'd1 : const_val;
        end else begin
            m_y = (m_y + 1) % V_ACT;
        end
        push_line(f);
    endtask

    task automatic pulse_sync(input bit f);
        f_sync = f;
        sync   = 1'b1;
        @(posedge clk); #1;
        sync   = 1'b0;
        f_sync = 1'b0;
    endtask

    task automatic do_line(input bit f);
        model_start(f);
        pulse_sync(f);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((line_busy || sb_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("line_done_in_time", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_eol(input int budget);
        int n = 0;
        while (!(pix_valid && pix_eol) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("eol_seen", 32'(n < budget), 32'd1);
    endtask

    // Ready driver: 1,0,0,1 pattern while backpressure is enabled.
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_en) begin
                pix_ready = bp_pat[bp_ph];
                bp_ph     = bp_ph + 2'd1;
            end else begin
                pix_ready = 1'b1;
            end
        end
    end

    // Monitor: compare the presented pixel, pop on transfer.
    always @(negedge clk) begin
        if (!rst && pix_valid) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_pixel", 32'(sb_q.size()), 32'd1);
            end else begin
                check_val("pix_data", 32'(pix_data), 32'(sb_q[0].d));
                check_val("pix_flags", 32'({pix_sol, pix_eol, pix_sof}),
                          32'({sb_q[0].sol, sb_q[0].eol, sb_q[0].sof}));
                if (m_mode == 3'd6) check_val("noise_nonzero", 32'(pix_data == 8'd0), 32'd0);
                if (pix_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; f_sync = 1'b0; sync = 1'b0; mode = 3'd0; const_val = 8'd0;
        dx = 2'd0; dy = 2'd0; cb_log2 = 2'd0; cb_inv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_flags", 32'({pix_valid, pix_sol, pix_eol, pix_sof, line_busy, sync_err}), 32'd0);
        check_val("reset_data", 32'(pix_data), 32'd0);
        rst = 1'b0;

        // disabled after reset, reserved mode at frame start: nothing emitted
        pulse_sync(1'b0);
        @(posedge clk); #1;
        check_val("disabled_idle", 32'({line_busy, sync_err}), 32'd0);
        mode = 3'd7;
        pulse_sync(1'b1);
        @(posedge clk); #1;
        check_val("rsvd_idle", 32'({line_busy, sync_err}), 32'd0);

        // COUNT: 4 lines, 0..31, latency 1
        mode = 3'd1;
        model_start(1'b1);
        check_val("pre_sync_valid", 32'(pix_valid), 32'd0);
        pulse_sync(1'b1);
        check_val("latency1_valid", 32'(pix_valid), 32'd1);
        wait_done(40);
        repeat (3) begin do_line(1'b0); wait_done(40); end

        // CHECK, tile 2, both polarities
        mode = 3'd3; cb_log2 = 2'd1; cb_inv = 1'b0;
        do_line(1'b1); wait_done(40);
        repeat (3) begin do_line(1'b0); wait_done(40); end
        cb_inv = 1'b1;
        do_line(1'b1); wait_done(40);
        repeat (3) begin do_line(1'b0); wait_done(40); end
        cb_log2 = 2'd0; cb_inv = 1'b0;
        do_line(1'b1); wait_done(40);

        // RAMP 10 + 2x + y, then 255 + 3x wrapping
        mode = 3'd4; const_val = 8'd10; dx = 2'd2; dy = 2'd1;
        do_line(1'b1); wait_done(40);
        do_line(1'b0); wait_done(40);
        const_val = 8'd255; dx = 2'd3; dy = 2'd0;
        do_line(1'b1); wait_done(40);

        // HBAR
        mode = 3'd5;
        do_line(1'b1); wait_done(40);
        do_line(1'b0); wait_done(40);

        // backpressure on CONST 0x5A and on COUNT (catches duplicates)
        bp_en = 1'b1;
        mode = 3'd2; const_val = 8'h5A;
        do_line(1'b1); wait_done(100);
        do_line(1'b0); wait_done(100);
        mode = 3'd1;
        do_line(1'b1); wait_done(100);
        do_line(1'b0); wait_done(100);
        bp_en = 1'b0;
        @(posedge clk); #1;

        // sync exactly on the eol transfer: back-to-back, no error
        mode = 3'd1;
        do_line(1'b1);
        wait_eol(40);
        do_line(1'b0);
        check_val("b2b_busy", 32'(line_busy), 32'd1);
        wait_done(40);
        check_val("b2b_no_err", 32'(sync_err), 32'd0);

        // sync mid-line: ignored, error flagged, line still completes
        do_line(1'b1);
        repeat (3) @(posedge clk);
        #1;
        pulse_sync(1'b0);
        check_val("midline_err", 32'(sync_err), 32'd1);
        wait_done(40);
        check_val("err_sticky", 32'(sync_err), 32'd1);

        // mode change mid-frame waits for the next frame start
        mode = 3'd1;
        do_line(1'b1); wait_done(40);
        mode = 3'd2; const_val = 8'h33;
        do_line(1'b0); wait_done(40);
        do_line(1'b1); wait_done(40);

        // NOISE with zero seed
        mode = 3'd6; const_val = 8'd0;
        do_line(1'b1); wait_done(40);
        repeat (3) begin do_line(1'b0); wait_done(40); end
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        // reset mid-line
        mode = 3'd2; const_val = 8'h77;
        do_line(1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_midline", 32'({pix_valid, line_busy, sync_err}), 32'd0);
        sb_q.delete();
        m_mode = 3'd0;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
